// File: rtl/serial_mod_n.sv
// ---------------------------------------------------------------------------
// serial_mod_n
//
// Serial residue tracker. It consumes one DIGIT_W-bit digit per accepted cycle,
// most-significant digit first, and keeps the running remainder of the number
// modulo MOD. It also reports divisibility and counts the digits in the
// current frame.
//
// Build option:
//   SERIAL_MOD_N_LOOKAHEAD_EN  When defined, rem_out and divisible are driven
//                              combinationally from the next-state value, so
//                              the result appears in the same cycle. When it is
//                              undefined (the default), every output is
//                              registered.
//
// Parameters:
//   modulus (MOD)         2..255
//   digit width (DIGIT_W) 1..8; the radix is 2**DIGIT_W
//   counter (CNT_W)       digit counter width, 2..16
//   remainder (REM_W)     derived from MOD and not meant to be overridden
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous start-of-frame; discards the current frame
//   in_valid     in_digit is consumed this cycle
//   in_digit     next digit, most-significant digit first
//   rem_out      current remainder, always less than MOD
//   divisible    frame holds at least one digit and the remainder is zero
//   digit_count  digits accepted in the current frame; saturates
//   count_sat    digit_count has reached 2**CNT_W-1
//
// States:
//   state | meaning
//   IDLE  | no digit accepted since reset or clear
//   RUN   | at least one digit accepted in the current frame
// ---------------------------------------------------------------------------
module serial_mod_n #(
    parameter int  MOD     = 3,
    parameter int  DIGIT_W = 1,
    parameter int  CNT_W   = 8,
    localparam int REM_W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] in_digit,
    output logic [REM_W-1:0]   rem_out,
    output logic               divisible,
    output logic [CNT_W-1:0]   digit_count,
    output logic               count_sat
);

    // The widest intermediate value is (MOD-1)*2**DIGIT_W + 2**DIGIT_W-1.
    // That value is below MOD*2**DIGIT_W, so it fits in EXT_W bits without
    // truncation.
    localparam int                EXT_W   = REM_W + DIGIT_W;
    localparam logic [EXT_W-1:0]  MOD_EXT = EXT_W'(MOD);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [REM_W-1:0]   rem, rem_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               sat, sat_next;
    logic [EXT_W-1:0]   base;
    logic [EXT_W-1:0]   acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rem   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            count <= count_next;
            sat   <= sat_next;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        count_next = count;
        sat_next   = sat;

        // A clear that arrives together with a digit drops the old history.
        // The digit then starts a new frame from a remainder of zero.
        base = clear ? '0 : {rem, {DIGIT_W{1'b0}}};
        acc  = base + EXT_W'(in_digit);

        if (in_valid) begin
            state_next = RUN;
            rem_next   = REM_W'(acc % MOD_EXT);
            if (clear) begin
                count_next = CNT_W'(1);
                sat_next   = 1'b0;
            end else begin
                if (count != CNT_MAX) begin
                    count_next = count + CNT_W'(1);
                end
                sat_next = sat | (count_next == CNT_MAX);
            end
        end else if (clear) begin
            state_next = IDLE;
            rem_next   = '0;
            count_next = '0;
            sat_next   = 1'b0;
        end
    end

    assign digit_count = count;
    assign count_sat   = sat;

`ifdef SERIAL_MOD_N_LOOKAHEAD_EN
    // Gate the lookahead path with reset. Otherwise the pending digit would
    // leak through while reset_n is low.
    assign rem_out   = reset_n ? rem_next : '0;
    assign divisible = reset_n && (state_next == RUN) && (rem_next == '0);
`else
    assign rem_out   = rem;
    assign divisible = (state == RUN) && (rem == '0);
`endif

endmodule

// File: tb/tb_serial_mod_n.sv
module tb_serial_mod_n;

    logic       clock = 1'b0;
    logic       reset_n;

    // Instance A: MOD=3, DIGIT_W=1, CNT_W=8
    logic       a_clr, a_vld;
    logic [0:0] a_dig;
    logic [1:0] a_rem;
    logic       a_div, a_sat;
    logic [7:0] a_cnt;

    // Instance B: MOD=7, DIGIT_W=4, CNT_W=8
    logic       b_clr, b_vld;
    logic [3:0] b_dig;
    logic [2:0] b_rem;
    logic       b_div, b_sat;
    logic [7:0] b_cnt;

    // Instance C: MOD=5, DIGIT_W=2, CNT_W=4
    logic       c_clr, c_vld;
    logic [1:0] c_dig;
    logic [2:0] c_rem;
    logic       c_div, c_sat;
    logic [3:0] c_cnt;

    serial_mod_n #(.MOD(3), .DIGIT_W(1), .CNT_W(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .clear(a_clr), .in_valid(a_vld),
        .in_digit(a_dig), .rem_out(a_rem), .divisible(a_div),
        .digit_count(a_cnt), .count_sat(a_sat));

    serial_mod_n #(.MOD(7), .DIGIT_W(4), .CNT_W(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .clear(b_clr), .in_valid(b_vld),
        .in_digit(b_dig), .rem_out(b_rem), .divisible(b_div),
        .digit_count(b_cnt), .count_sat(b_sat));

    serial_mod_n #(.MOD(5), .DIGIT_W(2), .CNT_W(4)) dut_c (
        .clock(clock), .reset_n(reset_n), .clear(c_clr), .in_valid(c_vld),
        .in_digit(c_dig), .rem_out(c_rem), .divisible(c_div),
        .digit_count(c_cnt), .count_sat(c_sat));

    always #5 clock = ~clock;

    typedef struct {
        int   sel;
        logic clr;
        logic vld;
        int   dig;
        int   rem;
        logic div;
        int   cnt;
        logic sat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int sel, input logic clr, input logic vld,
                                input int dig, input int rem, input logic div,
                                input int cnt, input logic sat);
        vec_t v;
        v.sel = sel; v.clr = clr; v.vld = vld; v.dig = dig;
        v.rem = rem; v.div = div; v.cnt = cnt; v.sat = sat;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_all();
        a_clr = 1'b0; a_vld = 1'b0; a_dig = '0;
        b_clr = 1'b0; b_vld = 1'b0; b_dig = '0;
        c_clr = 1'b0; c_vld = 1'b0; c_dig = '0;
    endtask

    task automatic read_dut(input int sel, output int rem, output int div,
                            output int cnt, output int sat);
        case (sel)
            0:       begin rem = int'(a_rem); div = int'(a_div); cnt = int'(a_cnt); sat = int'(a_sat); end
            1:       begin rem = int'(b_rem); div = int'(b_div); cnt = int'(b_cnt); sat = int'(b_sat); end
            default: begin rem = int'(c_rem); div = int'(c_div); cnt = int'(c_cnt); sat = int'(c_sat); end
        endcase
    endtask

    task automatic check_expect(input string tag, input vec_t e);
        int rem, div, cnt, sat;
        read_dut(e.sel, rem, div, cnt, sat);
        cmp($sformatf("%s dut%0d rem_out", tag, e.sel), rem, e.rem);
        cmp($sformatf("%s dut%0d divisible", tag, e.sel), div, int'(e.div));
        cmp($sformatf("%s dut%0d digit_count", tag, e.sel), cnt, e.cnt);
        cmp($sformatf("%s dut%0d count_sat", tag, e.sel), sat, int'(e.sat));
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected
    // outputs. The result is checked at the next falling edge, after the
    // rising edge has registered it.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        idle_all();
        case (v.sel)
            0:       begin a_clr = v.clr; a_vld = v.vld; a_dig = 1'(v.dig); end
            1:       begin b_clr = v.clr; b_vld = v.vld; b_dig = 4'(v.dig); end
            default: begin c_clr = v.clr; c_vld = v.vld; c_dig = 2'(v.dig); end
        endcase
        sb.push_back(v);
        @(posedge clock);
        @(negedge clock);
        idle_all();
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check_expect(tag, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset_n = 1'b0;
        idle_all();

        // Instance A, modulus 3 radix 2: stream 1,0,1,1, then clear, then 1,1,0 (value 6).
        // After that come a gap, a clear without a digit, and clear plus digit.
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 0, 4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 0, 2, 0));
        // Instance B, modulus 7 radix 16: 0xF,0xF gives 255 mod 7 = 3. Then clear with 0xA.
        vecs.push_back(mk(1, 0, 1, 15, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 15, 3, 0, 2, 0));
        vecs.push_back(mk(1, 1, 1, 10, 3, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 7, 6, 0, 2, 0));
        vecs.push_back(mk(1, 0, 1, 5, 3, 0, 3, 0));
        vecs.push_back(mk(1, 1, 1, 7, 0, 1, 1, 0));

        // Reset state, checked while reset is still asserted.
        repeat (2) @(negedge clock);
        for (int s = 0; s < 3; s++) check_expect("reset", mk(s, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Instance C, modulus 5 radix 4, CNT_W=4: 20 digits, so the counter saturates at 15.
        r = 0;
        for (int i = 0; i < 20; i++) begin
            int d;
            d = (i * 3 + 1) % 4;
            r = (r * 4 + d) % 5;
            apply($sformatf("sat%0d", i),
                  mk(2, 0, 1, d, r, (r == 0), (i + 1 > 15) ? 15 : i + 1, (i + 1 >= 15)));
        end
        apply("sat_gap", mk(2, 0, 0, 3, r, (r == 0), 15, 1));
        apply("sat_gap2", mk(2, 0, 0, 2, r, (r == 0), 15, 1));
        apply("sat_clear", mk(2, 1, 0, 0, 0, 0, 0, 0));

        // Re-saturate C, then reset mid-frame between edges. A still holds
        // rem 2 and B is divisible.
        for (int i = 0; i < 16; i++) begin
            idle_all(); c_vld = 1'b1; c_dig = 2'd1;
            @(posedge clock); @(negedge clock);
        end
        idle_all();
        check_expect("pre_reset", mk(0, 0, 0, 0, 2, 0, 2, 0));
        #2;
        reset_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) check_expect("async_reset", mk(s, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset_n = 1'b1;
        apply("post_reset1", mk(0, 0, 1, 1, 1, 0, 1, 0));
        apply("post_reset2", mk(0, 0, 1, 0, 2, 0, 2, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
